// File: rtl/fb_scanout.sv
// VGA scanout for a 320x240 RGB444 framebuffer, pixel-doubled to 640x480@60.
// Three-tick pipeline: address register, read-data capture, registered video outputs.
module fb_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FB_WIDTH = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_ce,
    output logic        frame_buf_enb,
    output logic [16:0] frame_buf_addrb,
    input  logic [11:0] frame_buf_doutb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0]   ROW_STEP = 17'(FB_WIDTH);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [16:0]   row_base;

    logic h_last;
    logic v_last;
    logic active;
    logic hs_n;
    logic vs_n;

    logic        hs_s1;
    logic        vs_s1;
    logic        act_s2;
    logic        hs_s2;
    logic        vs_s2;
    logic [11:0] pix_s2;

    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n   = !((h_cnt >= H_SS) && (h_cnt < H_SE));
        vs_n   = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    end

    // row_base tracks FB_WIDTH*(v_cnt>>1) incrementally: bump after each odd line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + V_ONE;
                    if (v_cnt[0]) begin
                        row_base <= row_base + ROW_STEP;
                    end
                end
            end else begin
                h_cnt <= h_cnt + H_ONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && h_last && v_last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_buf_enb   <= 1'b0;
            frame_buf_addrb <= '0;
            hs_s1           <= 1'b1;
            vs_s1           <= 1'b1;
            act_s2          <= 1'b0;
            hs_s2           <= 1'b1;
            vs_s2           <= 1'b1;
            pix_s2          <= '0;
            vga_rgb         <= '0;
            vga_hsync       <= 1'b1;
            vga_vsync       <= 1'b1;
        end else if (pix_ce) begin
            frame_buf_enb <= active;
            hs_s1         <= hs_n;
            vs_s1         <= vs_n;
            if (active) begin
                frame_buf_addrb <= row_base + 17'(h_cnt >> 1);
            end
            act_s2    <= frame_buf_enb;
            hs_s2     <= hs_s1;
            vs_s2     <= vs_s1;
            pix_s2    <= frame_buf_doutb;
            vga_rgb   <= act_s2 ? pix_s2 : '0;
            vga_hsync <= hs_s2;
            vga_vsync <= vs_s2;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a shrunken raster so whole frames fit in a short run;
// expected outputs come from tick-count arithmetic on raster position.
module tb_fb_scanout;

    localparam int HA  = 40;
    localparam int HF  = 4;
    localparam int HS  = 8;
    localparam int HB  = 6;
    localparam int VA  = 12;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int FBW = 20;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic        frame_buf_enb;
    logic [16:0] frame_buf_addrb;
    logic [11:0] frame_buf_doutb;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [11:0] vga_rgb;
    logic        frame_start;

    int unsigned mem_mode = 0;
    logic [11:0] mem_seed = 12'h000;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int last_addr = 0;
    int max_addr  = 0;
    int fs_count  = 0;

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_WIDTH(FBW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pix_ce         (pix_ce),
        .frame_buf_enb  (frame_buf_enb),
        .frame_buf_addrb(frame_buf_addrb),
        .frame_buf_doutb(frame_buf_doutb),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_rgb        (vga_rgb),
        .frame_start    (frame_start)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] mem_data(int unsigned mode, logic [11:0] seed, logic [16:0] a);
        logic [11:0] d;
        case (mode)
            0:       d = a[11:0];
            1:       d = 12'hFFF;
            default: d = a[11:0] ^ seed ^ {a[16:12], a[6:0]};
        endcase
        return d;
    endfunction

    // Read data is available before the next clock edge after the address changes.
    always_comb frame_buf_doutb = mem_data(mem_mode, mem_seed, frame_buf_addrb);

    function automatic bit is_active(int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic int addr_of(int p);
        return (((p / HT) % VT) / 2) * FBW + (p % HT) / 2;
    endfunction

    function automatic bit hs_exp(int p);
        int h = p % HT;
        return !((h >= HA + HF) && (h < HA + HF + HS));
    endfunction

    function automatic bit vs_exp(int p);
        int v = (p / HT) % VT;
        return !((v >= VA + VF) && (v < VA + VF + VS));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_reset_values();
        check("rst_rgb", vga_rgb, 12'h000);
        check("rst_hsync", vga_hsync, 1'b1);
        check("rst_vsync", vga_vsync, 1'b1);
        check("rst_enb", frame_buf_enb, 1'b0);
        check("rst_addr", frame_buf_addrb, 17'd0);
        check("rst_fstart", frame_start, 1'b0);
    endtask

    task automatic step(bit ce);
        logic [11:0] e_rgb;
        bit e_hs, e_vs, e_enb, e_fs;
        pix_ce = ce;
        @(posedge clock);
        #1;
        if (ce) begin
            k++;
            if (is_active(k - 1)) last_addr = addr_of(k - 1);
        end
        e_enb = (k >= 1) ? is_active(k - 1) : 1'b0;
        if (k >= 3) begin
            e_rgb = is_active(k - 3) ? mem_data(mem_mode, mem_seed, 17'(addr_of(k - 3))) : 12'h000;
            e_hs  = hs_exp(k - 3);
            e_vs  = vs_exp(k - 3);
        end else begin
            e_rgb = 12'h000;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
        end
        e_fs = ce && (k > 0) && ((k % FT) == 0);
        check("enb", frame_buf_enb, e_enb);
        check("addr", frame_buf_addrb, 17'(last_addr));
        check("rgb", vga_rgb, e_rgb);
        check("hsync", vga_hsync, e_hs);
        check("vsync", vga_vsync, e_vs);
        check("frame_start", frame_start, e_fs);
        if (int'(frame_buf_addrb) > max_addr) max_addr = int'(frame_buf_addrb);
        if (frame_start) fs_count++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        pix_ce = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        reset = 1'b0;
        k = 0;
        last_addr = 0;
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        pix_ce = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b0;

        // Continuous pixel clock, data = addr[11:0], two full frames.
        fs_count = 0;
        max_addr = 0;
        for (int i = 0; i < 2 * FT + 10; i++) step(1'b1);
        check("frame_start_count", 32'(fs_count), 32'd2);
        check("max_addr", 32'(max_addr), 32'((VA / 2 - 1) * FBW + FBW - 1));

        // Pixel enable every 4th clock, state must hold in between.
        fs_count = 0;
        for (int i = 0; i < FT + 2 * HT; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end
        check("frame_start_count_ce4", 32'(fs_count), 32'd1);

        // Mid-frame reset, then an all-white framebuffer.
        guard = 0;
        while (((k % FT) != (5 * HT + 19)) && (guard < FT + 1)) begin
            step(1'b1);
            guard++;
        end
        check("reset_position", 32'(k % FT), 32'(5 * HT + 19));
        mem_mode = 1;
        do_reset();
        for (int i = 0; i < FT + 3 * HT; i++) step(1'b1);

        // Random framebuffer contents and random pix_ce spacing.
        mem_mode = 2;
        mem_seed = 12'($urandom);
        do_reset();
        fs_count = 0;
        for (int i = 0; i < FT + HT; i++) begin
            int gap = int'($urandom_range(0, 3));
            for (int j = 0; j < gap; j++) step(1'b0);
            step(1'b1);
        end
        check("frame_start_count_rand", 32'(fs_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
